// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep sequencer: FSM state encoding,
// settle counter width and the row-count helper.
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int rows_of(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/gate_sweep_sequencer_settle_timer.sv
// Down-counter that times the settle interval; expired is high while the
// count sits at its final value so the FSM can leave on that cycle's edge.
module settle_timer
  import gate_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_value,
  input  logic                dec,
  output logic                expired
);

  logic [SETTLE_W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == SETTLE_W'(1));

endmodule

// File: rtl/gate_sweep_sequencer.sv
// Walks a combinational gate through every input row, samples its output after
// a settle delay and reports per-row mismatches against a latched truth table.
module gate_sweep_sequencer
  import gate_sweep_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 1,
  localparam int ROWS         = rows_of(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ROWS-1:0] expected,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ROWS-1:0] fail_mask,
  output logic [ROWS-1:0] observed
);

  localparam int ROW_W = (N_IN < 1) ? 1 : N_IN;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t          state, state_next;
  logic [ROW_W-1:0] row;
  logic [ROWS-1:0]  exp_q;
  logic             timer_load, timer_dec, timer_expired;
  logic             mismatch, sample_bit;

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (SETTLE_W'(SETTLE_CYCLES)),
    .dec        (timer_dec),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      IDLE:   if (start) state_next = APPLY;
      APPLY: begin
        if (SETTLE_CYCLES == 0) begin
          state_next = SAMPLE;
        end else begin
          timer_load = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        timer_dec = 1'b1;
        if (timer_expired) state_next = SAMPLE;
      end
      SAMPLE: state_next = (row == LAST_ROW) ? DONE : APPLY;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An unknown or floating gate output is a failure and is recorded as 0.
  assign mismatch   = (gate_out !== exp_q[row]);
  assign sample_bit = (gate_out === 1'b1);

  // NOTE: exp_q is a plain register, not a memory, so it is reset like the rest of the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_in   <= '0;
      pass      <= 1'b0;
      fail_mask <= '0;
      observed  <= '0;
      row       <= '0;
      exp_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q     <= expected;
            fail_mask <= '0;
            observed  <= '0;
            pass      <= 1'b0;
            row       <= '0;
            gate_in   <= '0;
          end
        end
        SAMPLE: begin
          observed[row]  <= sample_bit;
          fail_mask[row] <= mismatch;
          if (row == LAST_ROW) begin
            // Fold in the last row's result so pass is valid in the done cycle.
            pass <= ((fail_mask | (ROWS'(mismatch) << row)) == '0);
          end else begin
            row     <= row + 1'b1;
            gate_in <= N_IN'(row + 1'b1);
          end
        end
        DONE:    gate_in <= '0;
        default: ;
      endcase
    end
  end

  assign busy = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Bench for gate_sweep_sequencer: two instances (settle 1 and settle 0) each
// drive a table-defined gate; results are predicted from the sweep timing rules.
module tb_gate_sweep_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      start_v;
  logic [1:0][3:0] exp_v;
  logic [1:0][3:0] truth_v;
  logic [1:0][1:0] gi_v;
  logic [1:0]      gate_out_v;
  logic [1:0]      busy_v, done_v, pass_v;
  logic [1:0][3:0] fm_v, obs_v;

  // The gate under test is a lookup into a truth table indexed by its inputs.
  assign gate_out_v[0] = truth_v[0][gi_v[0]];
  assign gate_out_v[1] = truth_v[1][gi_v[1]];

  gate_sweep_sequencer #(.N_IN(2), .SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .expected(exp_v[0]),
    .gate_in(gi_v[0]), .gate_out(gate_out_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .pass(pass_v[0]), .fail_mask(fm_v[0]), .observed(obs_v[0])
  );

  gate_sweep_sequencer #(.N_IN(2), .SETTLE_CYCLES(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .expected(exp_v[1]),
    .gate_in(gi_v[1]), .gate_out(gate_out_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .pass(pass_v[1]), .fail_mask(fm_v[1]), .observed(obs_v[1])
  );

  localparam logic [3:0] AND_TT = 4'b1000;
  localparam logic [3:0] OR_TT  = 4'b1110;

  int errors = 0;
  int checks = 0;

  function automatic int settle_of(input int sel);
    return (sel == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    assert (act === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, req);
    end
  endtask

  task automatic check_all_zero(input int sel, input string tag);
    check({tag, "_gate_in"},   gi_v[sel],   0);
    check({tag, "_busy"},      busy_v[sel], 0);
    check({tag, "_done"},      done_v[sel], 0);
    check({tag, "_pass"},      pass_v[sel], 0);
    check({tag, "_fail_mask"}, fm_v[sel],   0);
    check({tag, "_observed"},  obs_v[sel],  0);
  endtask

  // One full sweep. Cycle k counts from the first cycle after the accept edge.
  // Each row occupies settle+2 cycles; done lands in cycle 4*(settle+2)+1.
  // disturb re-pulses start and flips expected in cycle 5; hold keeps start high.
  task automatic run_sweep(input int sel, input logic [3:0] tt, input logic [3:0] ev,
                           input bit disturb, input bit hold);
    int per, len;
    logic [3:0] fm_m;
    per  = settle_of(sel) + 2;
    len  = 4 * per + 1;
    fm_m = tt ^ ev;
    @(negedge clk);
    check($sformatf("s%0d_idle_busy", sel), busy_v[sel], 0);
    check($sformatf("s%0d_idle_done", sel), done_v[sel], 0);
    truth_v[sel] = tt;
    exp_v[sel]   = ev;
    start_v[sel] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) start_v[sel] = 1'b0;
      if (disturb && k == 5) begin
        start_v[sel] = 1'b1;
        exp_v[sel]   = ~ev;
      end
      if (disturb && k == 6 && !hold) start_v[sel] = 1'b0;
      check($sformatf("s%0d_gate_in_c%0d", sel, k), gi_v[sel], (k < len) ? (k - 1) / per : 3);
      check($sformatf("s%0d_busy_c%0d", sel, k), busy_v[sel], 32'(k < len));
      check($sformatf("s%0d_done_c%0d", sel, k), done_v[sel], 32'(k == len));
    end
    check($sformatf("s%0d_pass", sel),      pass_v[sel], 32'(fm_m == 4'b0));
    check($sformatf("s%0d_fail_mask", sel), fm_v[sel],   fm_m);
    check($sformatf("s%0d_observed", sel),  obs_v[sel],  tt);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    exp_v   = '0;
    truth_v = '0;
    #12;
    check_all_zero(0, "rst_s1");
    check_all_zero(1, "rst_s0");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sweeps on the settle-1 instance.
    run_sweep(0, AND_TT, 4'b1000, 1'b0, 1'b0);
    run_sweep(0, 4'b0000, 4'b1000, 1'b0, 1'b0);
    run_sweep(0, OR_TT, 4'b1000, 1'b0, 1'b0);

    // Results hold while idle.
    repeat (3) @(negedge clk);
    check("hold_pass", pass_v[0], 0);
    check("hold_fail_mask", fm_v[0], 4'b0110);
    check("hold_observed", obs_v[0], OR_TT);
    check("hold_gate_in", gi_v[0], 0);

    // Zero settle time.
    run_sweep(1, AND_TT, 4'b1000, 1'b0, 1'b0);

    // Mid-sweep start and expected changes are ignored.
    run_sweep(0, AND_TT, 4'b1000, 1'b1, 1'b0);

    // Start held through DONE: the next sweep is accepted in the following idle cycle.
    run_sweep(0, AND_TT, 4'b1000, 1'b0, 1'b1);
    run_sweep(0, OR_TT, OR_TT, 1'b0, 1'b0);

    // Reset during row 2 settle aborts with no done pulse.
    @(negedge clk);
    truth_v[0] = 4'b1111;
    exp_v[0]   = 4'b1000;
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start_v[0] = 1'b0;
    end
    check("abort_pre_gate_in", gi_v[0], 2);
    check("abort_pre_busy", busy_v[0], 1);
    check("abort_pre_observed", obs_v[0], 4'b0011);
    check("abort_pre_fail_mask", fm_v[0], 4'b0011);
    #1 rst_n = 1'b0;
    #1 check_all_zero(0, "abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_done_c%0d", k), done_v[0], 0);
    end
    rst_n = 1'b1;
    run_sweep(0, AND_TT, 4'b1000, 1'b0, 1'b0);

    // Randomized tables on both instances; some expected tables match to exercise pass.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] tt, ev;
      tt = 4'($urandom);
      ev = (i % 3 == 0) ? tt : 4'($urandom);
      run_sweep(i % 2, tt, ev, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
